data_unpack_gearbox: RTL and testbench

DATA_UNPACK_GEARBOX -- requirements
Module: data_unpack_gearbox

---
 rtl/data_unpack_gearbox_if.sv | 32 +++
 rtl/data_unpack_gearbox.sv | 129 ++++++++++++
 tb/tb_data_unpack_gearbox.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_unpack_gearbox_if.sv
// Handshake bundle between a word-wide producer and a symbol-wide consumer around the unpack gearbox.
// Latency: none, wires only.
// Backpressure: valid/ready on both sides; the slave modport is the gearbox view.
interface data_unpack_gearbox_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 7
);
    localparam int PAD_W = $clog2(OUT_W + 1);

    logic             valid_in;
    logic             ready_out;
    logic [IN_W-1:0]  data_in;
    logic             sop_in;
    logic             eop_in;
    logic             valid_out;
    logic             ready_in;
    logic [OUT_W-1:0] data_out;
    logic             sop_out;
    logic             eop_out;
    logic [PAD_W-1:0] pad_out;
    logic             err_out;

    modport master (
        output valid_in, data_in, sop_in, eop_in, ready_in,
        input  ready_out, valid_out, data_out, sop_out, eop_out, pad_out, err_out
    );

    modport slave (
        input  valid_in, data_in, sop_in, eop_in, ready_in,
        output ready_out, valid_out, data_out, sop_out, eop_out, pad_out, err_out
    );
endinterface

// File: rtl/data_unpack_gearbox.sv
// Unpacks IN_W-bit packet words LSB-first into OUT_W-bit symbols, zero-padding the last symbol of a packet.
// Latency: first symbol is valid the cycle after the sop word is accepted.
// Backpressure: a word is taken only while fewer than OUT_W bits are buffered; symbols hold while ready_in is low.
module data_unpack_gearbox #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    data_unpack_gearbox_if.slave  bus
);
    localparam int BUF_W  = IN_W + OUT_W - 1;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int PAD_W  = $clog2(OUT_W + 1);

    localparam logic [FILL_W-1:0] OUT_F = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] IN_F  = FILL_W'(IN_W);

    if (OUT_W < 1 || OUT_W > IN_W) begin : g_cfg_err
        $error("data_unpack_gearbox: OUT_W must be in 1..IN_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PKT,
        S_DRAIN
    } state_t;

    state_t             state, state_n;
    logic [BUF_W-1:0]   buffer, buffer_n;
    logic [FILL_W-1:0]  fill, fill_n;
    logic               sop_flag, sop_flag_n;
    logic               err, err_n;

    logic               eop_pending;
    logic               have_sym;
    logic               last_sym;
    logic               short_sym;
    logic               rdy;
    logic               vld;
    logic               in_fire;
    logic               out_fire;
    logic [FILL_W-1:0]  gap;

    assign eop_pending = (state == S_DRAIN);
    assign have_sym    = (fill >= OUT_F) || (eop_pending && (fill != '0));
    assign last_sym    = eop_pending && (fill <= OUT_F);
    assign short_sym   = eop_pending && (fill < OUT_F);

    // Ready and valid are mutually exclusive: ready needs fill < OUT_W outside DRAIN,
    // valid needs fill >= OUT_W or DRAIN.
    assign rdy      = !rst && !eop_pending && (fill < OUT_F);
    assign vld      = !rst && have_sym;
    assign in_fire  = bus.valid_in && rdy;
    assign out_fire = vld && bus.ready_in;
    assign gap      = OUT_F - fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            buffer   <= '0;
            fill     <= '0;
            sop_flag <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            buffer   <= buffer_n;
            fill     <= fill_n;
            sop_flag <= sop_flag_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        buffer_n   = buffer;
        fill_n     = fill;
        sop_flag_n = sop_flag;
        err_n      = err;

        if (in_fire) begin
            unique case (state)
                S_IDLE: begin
                    if (bus.sop_in) begin
                        buffer_n   = BUF_W'(bus.data_in);
                        fill_n     = IN_F;
                        sop_flag_n = 1'b1;
                        state_n    = bus.eop_in ? S_DRAIN : S_PKT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                S_PKT: begin
                    if (bus.sop_in) begin
                        // A new sop restarts at bit 0; residual bits of the open packet are dropped.
                        err_n      = 1'b1;
                        buffer_n   = BUF_W'(bus.data_in);
                        fill_n     = IN_F;
                        sop_flag_n = 1'b1;
                    end else begin
                        buffer_n = buffer | (BUF_W'(bus.data_in) << fill);
                        fill_n   = fill + IN_F;
                    end
                    if (bus.eop_in) begin
                        state_n = S_DRAIN;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end else if (out_fire) begin
            buffer_n   = buffer >> OUT_W;
            fill_n     = (fill > OUT_F) ? (fill - OUT_F) : '0;
            sop_flag_n = 1'b0;
            if (eop_pending && (fill <= OUT_F)) begin
                state_n = S_IDLE;
            end
        end
    end

    assign bus.ready_out = rdy;
    assign bus.valid_out = vld;
    assign bus.data_out  = rst ? '0 : buffer[OUT_W-1:0];
    assign bus.sop_out   = vld && sop_flag;
    assign bus.eop_out   = vld && last_sym;
    assign bus.pad_out   = (vld && short_sym) ? PAD_W'(gap) : '0;
    assign bus.err_out   = err;
endmodule

// File: tb/tb_data_unpack_gearbox.sv
// Bench for data_unpack_gearbox: bit-queue packet model checked on every symbol, plus directed literal checks.
module tb_data_unpack_gearbox;
    localparam int IN_W  = 32;
    localparam int OUT_W = 7;
    localparam int PW    = $clog2(OUT_W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_unpack_gearbox_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    data_unpack_gearbox #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             sop;
        logic             eop;
        logic [PW-1:0]    pad;
    } sym_t;

    sym_t exp_q[$];
    sym_t obs_q[$];
    bit   bits_q[$];
    bit   pkt_open;
    bit   first_sym;
    bit   err_exp;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: a packet is a stream of bits cut into OUT_W chunks; the tail is zero-padded on eop.
    task automatic model_word(input logic [IN_W-1:0] d, input logic sop, input logic eop);
        sym_t s;
        if (!pkt_open && !sop) begin
            err_exp = 1'b1;
            return;
        end
        if (sop) begin
            if (pkt_open) err_exp = 1'b1;
            bits_q.delete();
            first_sym = 1'b1;
            pkt_open  = 1'b1;
        end
        for (int i = 0; i < IN_W; i++) bits_q.push_back(d[i]);
        while (bits_q.size() >= OUT_W) begin
            s.d = '0;
            for (int j = 0; j < OUT_W; j++) s.d[j] = bits_q.pop_front();
            s.sop = first_sym; s.eop = 1'b0; s.pad = '0;
            first_sym = 1'b0;
            exp_q.push_back(s);
        end
        if (eop) begin
            if (bits_q.size() > 0) begin
                s.d   = '0;
                s.pad = PW'(OUT_W - bits_q.size());
                for (int j = 0; j < OUT_W; j++)
                    if (bits_q.size() > 0) s.d[j] = bits_q.pop_front();
                s.sop = first_sym; s.eop = 1'b0;
                first_sym = 1'b0;
                exp_q.push_back(s);
            end
            s = exp_q.pop_back();
            s.eop = 1'b1;
            exp_q.push_back(s);
            pkt_open = 1'b0;
        end
    endtask

    sym_t prev;
    sym_t cur;
    sym_t e;
    bit   prev_stall;

    always @(negedge clk) begin
        cur.d = bus.data_out; cur.sop = bus.sop_out; cur.eop = bus.eop_out; cur.pad = bus.pad_out;
        if (rst) begin
            chk("rst_valid_out", bus.valid_out, 0);
            chk("rst_ready_out", bus.ready_out, 0);
            chk("rst_sop_out",   bus.sop_out,   0);
            chk("rst_eop_out",   bus.eop_out,   0);
            chk("rst_data_out",  bus.data_out,  0);
            chk("rst_pad_out",   bus.pad_out,   0);
            exp_q.delete(); bits_q.delete();
            pkt_open = 1'b0; first_sym = 1'b0; err_exp = 1'b0; prev_stall = 1'b0;
        end else begin
            chk("err_out", bus.err_out, err_exp);
            chk("valid_ready_excl", bus.valid_out && bus.ready_out, 0);
            if (prev_stall) begin
                chk("stall_valid", bus.valid_out, 1);
                chk("stall_data",  cur.d,   prev.d);
                chk("stall_sop",   cur.sop, prev.sop);
                chk("stall_eop",   cur.eop, prev.eop);
                chk("stall_pad",   cur.pad, prev.pad);
            end
            if (bus.valid_out && bus.ready_in) begin
                chk("symbol_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sym_data", cur.d,   e.d);
                    chk("sym_sop",  cur.sop, e.sop);
                    chk("sym_eop",  cur.eop, e.eop);
                    chk("sym_pad",  cur.pad, e.pad);
                end
                obs_q.push_back(cur);
            end
            prev_stall = bus.valid_out && !bus.ready_in;
            prev = cur;
            if (bus.valid_in && bus.ready_out) model_word(bus.data_in, bus.sop_in, bus.eop_in);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic s, input logic e);
        int n = 0;
        bus.data_in = d; bus.sop_in = s; bus.eop_in = e; bus.valid_in = 1'b1;
        @(negedge clk);
        while (!bus.ready_out && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", bus.ready_out, 1);
        tick();
        bus.valid_in = 1'b0; bus.sop_in = 1'b0; bus.eop_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.valid_out) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (exp_q.size() == 0) && !bus.valid_out, 1);
        tick();
    endtask

    task automatic single_word_test();
        int base = obs_q.size();
        send(32'h89ABCDEF, 1'b1, 1'b1);
        @(negedge clk);
        chk("first_sym_latency", bus.valid_out, 1);
        tick();
        wait_idle();
        chk("single_count", obs_q.size() - base, 5);
        if (obs_q.size() - base == 5) begin
            chk("single_first_data", obs_q[base].d,     7'h6F);
            chk("single_first_sop",  obs_q[base].sop,   1);
            chk("single_first_eop",  obs_q[base].eop,   0);
            chk("single_last_data",  obs_q[base+4].d,   7'h08);
            chk("single_last_eop",   obs_q[base+4].eop, 1);
            chk("single_last_pad",   obs_q[base+4].pad, 3);
        end
    endtask

    logic [IN_W-1:0] words [7];
    logic [OUT_W-1:0] held;

    initial begin
        int base;
        int eops;
        bus.valid_in = 1'b0; bus.data_in = '0; bus.sop_in = 1'b0; bus.eop_in = 1'b0; bus.ready_in = 1'b1;
        checks = 0; errors = 0;
        tick();
        do_reset(2);
        @(negedge clk);
        chk("post_rst_ready", bus.ready_out, 1);
        chk("post_rst_valid", bus.valid_out, 0);
        chk("post_rst_err",   bus.err_out,   0);
        tick();

        single_word_test();

        words[0] = 32'h01234567; words[1] = 32'h89ABCDEF; words[2] = 32'hDEADBEEF;
        words[3] = 32'hCAFEF00D; words[4] = 32'h0F0F0F0F; words[5] = 32'hFFFFFFFF;
        words[6] = 32'h12345678;
        base = obs_q.size();
        for (int i = 0; i < 7; i++) send(words[i], i == 0, i == 6);
        wait_idle();
        chk("seven_count", obs_q.size() - base, 32);
        eops = 0;
        for (int i = base; i < obs_q.size(); i++) if (obs_q[i].eop) eops++;
        chk("seven_eop_count", eops, 1);
        if (obs_q.size() - base == 32) begin
            chk("seven_last_eop", obs_q[base+31].eop, 1);
            chk("seven_last_pad", obs_q[base+31].pad, 0);
        end

        send(32'h13579BDF, 1'b1, 1'b0);
        tick(); tick();
        bus.ready_in = 1'b0;
        @(negedge clk);
        held = bus.data_out;
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld_hi",  bus.valid_out, 1);
            chk("stall_rdy_lo",  bus.ready_out, 0);
            chk("stall_hold",    bus.data_out,  held);
            @(negedge clk);
        end
        tick();
        bus.ready_in = 1'b1;
        send(32'h2468ACE0, 1'b0, 1'b1);
        wait_idle();

        do_reset(1);
        @(negedge clk);
        chk("pre_err_clear", bus.err_out, 0);
        tick();
        send(32'h11111111, 1'b1, 1'b0);
        send(32'h22222222, 1'b0, 1'b0);
        send(32'hA5A5A5A5, 1'b1, 1'b1);
        base = obs_q.size();
        @(negedge clk);
        chk("resync_err", bus.err_out, 1);
        tick();
        wait_idle();
        chk("resync_count_ok", obs_q.size() > base, 1);
        if (obs_q.size() > base) begin
            chk("resync_data", obs_q[base].d,   7'h25);
            chk("resync_sop",  obs_q[base].sop, 1);
        end

        do_reset(1);
        send(32'h12345678, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_no_valid", bus.valid_out, 0);
            chk("stray_err",      bus.err_out,   1);
        end
        tick();

        send(32'hFEDCBA98, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", bus.valid_out, 0);
        chk("mid_rst_sop",   bus.sop_out,   0);
        chk("mid_rst_eop",   bus.eop_out,   0);
        chk("mid_rst_data",  bus.data_out,  0);
        chk("mid_rst_pad",   bus.pad_out,   0);
        chk("mid_rst_err",   bus.err_out,   0);
        chk("mid_rst_ready", bus.ready_out, 1);
        tick();
        single_word_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
